dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words backed.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra response wait states; used only when DMEM_WAIT_STATE_EN is defined.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port async_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 SHALL have port req_unsigned  input  1  zero-extend loads (LBU/LHU) when 1.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  core consumes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned, illegal-size or out-of-range request.

Function
REQ-016 SHALL implement the FSM IDLE -> (WAIT) -> RESP -> IDLE.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid && req_ready.
REQ-018 SHALL commit a legal store to memory on the acceptance edge, with byte lanes selected by req_size and req_addr[1:0].
REQ-019 SHALL read memory synchronously on the acceptance edge, then extend the addressed byte or half: sign-extend, or zero-extend when req_unsigned = 1.
REQ-020 SHALL flag an error when:
- req_size = 11;
- half access has addr[0] = 1;
- word access has addr[1:0] != 0;
- addr[31:2] >= DEPTH_WORDS.
REQ-021 SHALL, on error, suppress the write, return rsp_rdata = 0 and assert rsp_err = 1.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-023 SHALL have no request overlap: a new request is accepted at the earliest on the cycle after the response handshake.
REQ-024 SHALL ignore req_* while not in IDLE.

Reset
REQ-025 SHALL, while async_rst = 1, force state = IDLE, req_ready = 0, rsp_valid = 0, rsp_rdata = 0 and rsp_err = 0.
REQ-026 SHALL set req_ready = 1 on the first cycle after reset deasserts.
REQ-027 SHALL NOT reset memory contents.
REQ-028 SHALL, when reset asserts mid-transaction, drop the pending response; a store accepted before reset remains committed.

Configuration
REQ-029 SHALL, with DMEM_WAIT_STATE_EN defined, pass through WAIT for exactly WAIT_CYCLES cycles via a down-counter, so rsp_valid rises WAIT_CYCLES+1 cycles after acceptance; WAIT_CYCLES = 0 skips WAIT.
REQ-030 SHALL, without DMEM_WAIT_STATE_EN, omit WAIT and the counter; rsp_valid rises 1 cycle after acceptance.

Structure
REQ-031 SHALL place the size encodings, FSM state encoding and error-check constants in shared package dmem_pkg.
REQ-032 SHALL instantiate one sub-module, dmem_ram: a DEPTH_WORDS x 32 synchronous RAM with 4-bit byte enable.

Verification
REQ-033 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; latency 1 cycle (3 cycles with macro, WAIT_CYCLES = 2).
REQ-034 LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
REQ-035 SH 0x1234 @0x11 -> rsp_err = 1, rsp_rdata = 0; a following LW @0x10 still returns 0xDEADBEEF.
REQ-036 LW @(DEPTH_WORDS*4) -> rsp_err = 1; req_size = 11 -> rsp_err = 1.
REQ-037 Hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stay stable, req_ready = 0, and a concurrent req_valid is ignored.
REQ-038 Assert async_rst during RESP after SW 0x55 @0x20 -> rsp_valid = 0 immediately, req_ready = 1 after release, and LW @0x20 returns 0x00000055.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder: access sizes,
// FSM states, alignment masks and the lane/extension functions.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] HALF_MISALIGN_MASK = 2'b01;
  localparam logic [1:0] WORD_MISALIGN_MASK = 2'b11;

  function automatic logic req_error(input size_e size, input logic [31:0] addr,
                                     input int unsigned depth);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF:    bad = |(addr[1:0] & HALF_MISALIGN_MASK);
      SZ_WORD:    bad = |(addr[1:0] & WORD_MISALIGN_MASK);
      SZ_ILLEGAL: bad = 1'b1;
      default:    bad = 1'b0;
    endcase
    if (32'(addr[31:2]) >= depth) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input size_e size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data is replicated so every enabled lane sees it.
  function automatic logic [31:0] wdata_lanes(input size_e size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input size_e size, input logic [1:0] off,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: d = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_HALF: d = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: d = word;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// DEPTH_WORDS x 32 synchronous RAM with byte enables; read returns the
// contents before any same-edge write. Contents are never reset.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= r_mem[addr];
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: IDLE -> (WAIT) -> RESP -> IDLE.
// Define DMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states before RESP.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        async_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  import dmem_pkg::*;

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      r_state, w_next;
  logic        w_ready, w_accept, w_err;
  size_e       w_size;
  logic [31:0] w_rdata;

  logic        r_we, r_err, r_uns;
  size_e       r_size;
  logic [1:0]  r_off;

  assign w_size   = size_e'(req_size);
  assign w_err    = req_error(w_size, req_addr, DEPTH_WORDS);
  assign w_accept = req_valid && w_ready;

`ifdef DMEM_WAIT_STATE_EN
  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= CNT_LOAD;
    end else if (r_state == ST_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (req_valid) begin
`ifdef DMEM_WAIT_STATE_EN
          w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
`else
          w_next = ST_RESP;
`endif
        end
      end
      ST_WAIT: begin
`ifdef DMEM_WAIT_STATE_EN
        if (r_cnt == '0) w_next = ST_RESP;
`else
        w_next = ST_RESP;
`endif
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State is already IDLE under reset, so ready must also be gated by the reset input.
  assign req_ready = w_ready && !async_rst;

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      r_we   <= 1'b0;
      r_err  <= 1'b0;
      r_uns  <= 1'b0;
      r_size <= SZ_BYTE;
      r_off  <= '0;
    end else if (w_accept) begin
      r_we   <= req_we;
      r_err  <= w_err;
      r_uns  <= req_unsigned;
      r_size <= w_size;
      r_off  <= req_addr[1:0];
    end
  end

  // RAM is only enabled on acceptance, so its output holds through WAIT and RESP.
  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .en    (w_accept && !w_err),
    .we    (req_we),
    .be    (byte_en(w_size, req_addr[1:0])),
    .addr  (req_addr[AW+1:2]),
    .wdata (wdata_lanes(w_size, req_wdata)),
    .rdata (w_rdata)
  );

  assign rsp_err   = (r_state == ST_RESP) && r_err;
  assign rsp_rdata = (r_state == ST_RESP && !r_err && !r_we)
                   ? load_extend(r_size, r_off, r_uns, w_rdata) : '0;

endmodule
